bus_wait_decoder: RTL
=====================

BUS_WAIT_DECODER -- requirements
Module: bus_wait_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, 16, CPU address bus width.
REQ-002 Parameter WAIT0, 2, wait cycles inserted for region 0 (addr MSB = 0), range 0..15.
REQ-003 Parameter WAIT1, 0, wait cycles inserted for region 1 (addr MSB = 1), range 0..15.
REQ-004 Parameter TIMEOUT, 16, maximum cycles the peripheral may hold periph_wait_n low, range 2..255.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset is synchronous and active-high.
REQ-007 mreq_n  input  1  CPU memory request, active low.
REQ-008 iorq_n  input  1  CPU I/O request, active low; not decoded by this block.
REQ-009 rd_n  input  1  CPU read strobe, active low.
REQ-010 wr_n  input  1  CPU write strobe, active low.
REQ-011 addr  input  ADDR_WIDTH  CPU address.
REQ-012 periph_wait_n  input  1  wired-AND wait request from peripherals, active low.
REQ-013 clr_timeout  input  1  one-cycle pulse clearing the timeout flag.
REQ-014 periph_en_n  output  2  per-region peripheral enable, active low.
REQ-015 buswait_n  output  1  wait request to CPU, active low.
REQ-016 timeout  output  1  sticky flag: a peripheral wait was force-terminated.

Function
REQ-017 periph_en_n[r] SHALL be combinational: low iff mreq_n=0 and addr[ADDR_WIDTH-1]=r; zero latency.
REQ-018 Access start SHALL be detected in IDLE when mreq_n=0 and (rd_n=0 or wr_n=0); region r latched from addr MSB in that cycle.
REQ-019 FSM states SHALL be IDLE, WAIT, EXT, DONE.
REQ-020 IDLE->WAIT on start when WAITr>0, loading the down-counter with WAITr-1; IDLE->EXT on start when WAITr=0.
REQ-021 WAIT SHALL drive buswait_n=0; counter decrements each cycle; WAIT->EXT in the cycle the counter is 0; buswait_n is therefore low for exactly WAITr cycles, starting the cycle after start.
REQ-022 EXT SHALL drive buswait_n = periph_wait_n; the timeout counter clears on EXT entry and increments each cycle periph_wait_n=0.
REQ-023 EXT->DONE when periph_wait_n=1, or when the timeout counter reaches TIMEOUT-1 with periph_wait_n=0; in the latter cycle buswait_n SHALL be forced 1 and timeout set on the next edge.
REQ-024 DONE SHALL drive buswait_n=1; DONE->IDLE when mreq_n=1.
REQ-025 mreq_n=1 in WAIT or EXT SHALL abort: next state IDLE, buswait_n=1 from that cycle, timeout unchanged.
REQ-026 iorq_n=0 accesses (mreq_n=1) SHALL leave the FSM in IDLE, all periph_en_n high, buswait_n high.
REQ-027 A new access SHALL NOT start until the FSM has passed through IDLE with mreq_n=1 at least once (no back-to-back restart from DONE).
REQ-028 timeout set and clr_timeout in the same cycle: set SHALL win.
REQ-029 Counters SHALL be wide enough for the parameter ranges (4-bit wait, 8-bit timeout); no wrap-around occurs in legal operation.

Reset
REQ-030 reset=1 at a rising edge SHALL force state IDLE, both counters 0, timeout=0, buswait_n=1, regardless of current access.
REQ-031 periph_en_n SHALL remain purely combinational during reset.

Structure
REQ-032 Package bus_pkg SHALL hold bus_addr_t, bus_data_t and the FSM state enum, shared with cpu and peripheral models.
REQ-033 One sub-module bus_wait_counter (loadable down-counter with zero flag) SHALL implement the WAIT counter.

Verification
REQ-034 WAIT0=2, read addr 16'h0010, periph_wait_n=1 -> periph_en_n=2'b10, buswait_n low exactly 2 cycles, then DONE.
REQ-035 WAIT1=0, write addr 16'h8000, periph_wait_n low 3 cycles -> periph_en_n=2'b01, buswait_n low exactly 3 cycles, timeout=0.
REQ-036 TIMEOUT=16, periph_wait_n held low -> buswait_n low 15 cycles then high, timeout=1 until clr_timeout pulse, then 0.
REQ-037 mreq_n released in 2nd WAIT cycle of region-0 access -> FSM IDLE next edge, buswait_n=1, next access gets full 2 waits.
REQ-038 reset asserted mid-EXT with periph_wait_n=0 -> next edge buswait_n=1, timeout=0, IDLE; iorq_n=0 cycle afterwards -> no enables, no waits.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg
// Shared bus types and FSM state encoding for the wait-state decoder and
// for the CPU and peripheral models that drive it.
//   bus_addr_t  : CPU address word
//   bus_data_t  : CPU data word
//   bus_state_t : access-sequencing FSM state
package bus_pkg;

   localparam int BUS_ADDR_W  = 16;
   localparam int BUS_DATA_W  = 8;
   localparam int WAIT_CNT_W  = 4;   // holds wait counts 0..15
   localparam int TMO_CNT_W   = 8;   // holds timeout counts up to 254

   typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
   typedef logic [BUS_DATA_W-1:0] bus_data_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EXT  = 2'd2,
      ST_DONE = 2'd3
   } bus_state_t;

   // Down-counter preload for a wait count; zero waits never loads.
   function automatic logic [WAIT_CNT_W-1:0] wait_preload(input logic [WAIT_CNT_W-1:0] waits);
      return (waits == '0) ? '0 : waits - 1'b1;
   endfunction

endpackage

// File: rtl/bus_wait_decoder_if.sv
// bus_wait_decoder_if
// CPU-side bus and peripheral handshake seen by the wait-state decoder.
//   slave  : decoder side (takes strobes/address/wait, drives enables/wait/timeout)
//   master : CPU/peripheral model side
// Signals:
//   mreq_n, iorq_n, rd_n, wr_n : CPU strobes, active low
//   addr                       : CPU address
//   periph_wait_n              : wired-AND peripheral wait, active low
//   clr_timeout                : one-cycle clear of the sticky timeout flag
//   periph_en_n[1:0]           : per-region enables, active low
//   buswait_n                  : wait request to CPU, active low
//   timeout                    : sticky forced-termination flag
interface bus_wait_decoder_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  mreq_n;
   logic                  iorq_n;
   logic                  rd_n;
   logic                  wr_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  periph_wait_n;
   logic                  clr_timeout;
   logic [1:0]            periph_en_n;
   logic                  buswait_n;
   logic                  timeout;

   modport slave (
      input  mreq_n, iorq_n, rd_n, wr_n, addr, periph_wait_n, clr_timeout,
      output periph_en_n, buswait_n, timeout
   );

   modport master (
      output mreq_n, iorq_n, rd_n, wr_n, addr, periph_wait_n, clr_timeout,
      input  periph_en_n, buswait_n, timeout
   );
endinterface

// File: rtl/bus_wait_counter.sv
// bus_wait_counter
// Loadable down-counter with terminal-count (zero) flag for inserted waits.
//   clk, reset : clock, synchronous active-high reset
//   load       : load count with load_val (wins over dec)
//   load_val   : preload value
//   dec        : decrement; holds at zero
//   count      : current value
//   zero       : count == 0
module bus_wait_counter
   import bus_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] load_val,
   input  logic                  dec,
   output logic [WAIT_CNT_W-1:0] count,
   output logic                  zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bus_wait_decoder.sv
// bus_wait_decoder
// Decodes the CPU address into two peripheral regions, inserts a fixed
// number of wait states per region, then passes the peripheral wait through
// with a timeout that force-terminates a stuck peripheral.
//   clk   : single clock
//   reset : synchronous, active high
//   bus   : bus_wait_decoder_if.slave (strobes, address, waits, enables, timeout)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access; waits for a start after mreq_n has been seen high
// WAIT  | inserting fixed region wait states, buswait_n low
// EXT   | peripheral owns buswait_n; timeout counter running
// DONE  | access finished, buswait_n high until mreq_n is released
module bus_wait_decoder
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int WAIT0      = 2,
   parameter int WAIT1      = 0,
   parameter int TIMEOUT    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   bus_wait_decoder_if.slave      bus
);

   localparam logic [WAIT_CNT_W-1:0] WAIT0_V  = WAIT_CNT_W'(WAIT0);
   localparam logic [WAIT_CNT_W-1:0] WAIT1_V  = WAIT_CNT_W'(WAIT1);
   // The timeout timer counts down from TIMEOUT-1; reaching zero while the
   // peripheral still holds wait marks the forced-termination cycle.
   localparam logic [TMO_CNT_W-1:0]  TMO_LOAD = TMO_CNT_W'(TIMEOUT - 1);

   bus_state_t            state_q, state_d;
   logic                  armed_q;
   logic                  start;
   logic                  region;
   logic [WAIT_CNT_W-1:0] wait_sel;

   logic                  wcnt_load, wcnt_dec, wcnt_zero;
   logic [WAIT_CNT_W-1:0] wcnt_ld_val, wcnt_count;

   logic [TMO_CNT_W-1:0]  tmo_cnt_q;
   logic                  tmo_load, tmo_dec, tmo_zero, tmo_set;
   logic                  timeout_q;
   logic                  buswait_n_c;

   // iorq_n and the low address bits are not decoded here.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.iorq_n, bus.addr[ADDR_WIDTH-2:0], wcnt_count};

   assign region = bus.addr[ADDR_WIDTH-1];

   // Enables are pure decode so they follow mreq_n/addr even during reset.
   assign bus.periph_en_n[0] = ~(~bus.mreq_n & ~region);
   assign bus.periph_en_n[1] = ~(~bus.mreq_n &  region);

   assign wait_sel = region ? WAIT1_V : WAIT0_V;

   // A start needs a prior IDLE cycle with mreq_n high, so an access that
   // ends (or aborts) cannot immediately retrigger on the same mreq_n.
   assign start = (state_q == ST_IDLE) && armed_q && !bus.mreq_n &&
                  (!bus.rd_n || !bus.wr_n);

   bus_wait_counter u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (wcnt_load),
      .load_val (wcnt_ld_val),
      .dec      (wcnt_dec),
      .count    (wcnt_count),
      .zero     (wcnt_zero)
   );

   assign tmo_zero = (tmo_cnt_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         armed_q   <= 1'b0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;

         if (start) begin
            armed_q <= 1'b0;
         end else if (state_q == ST_IDLE && bus.mreq_n) begin
            armed_q <= 1'b1;
         end

         if (tmo_load) begin
            tmo_cnt_q <= TMO_LOAD;
         end else if (tmo_dec && !tmo_zero) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
         end

         // A set in the same cycle as a clear must not be lost.
         if (tmo_set) begin
            timeout_q <= 1'b1;
         end else if (bus.clr_timeout) begin
            timeout_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_load   = 1'b0;
      wcnt_ld_val = '0;
      wcnt_dec    = 1'b0;
      tmo_load    = 1'b0;
      tmo_dec     = 1'b0;
      tmo_set     = 1'b0;
      buswait_n_c = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (wait_sel != '0) begin
                  state_d     = ST_WAIT;
                  wcnt_load   = 1'b1;
                  wcnt_ld_val = wait_preload(wait_sel);
               end else begin
                  state_d  = ST_EXT;
                  tmo_load = 1'b1;
               end
            end
         end

         ST_WAIT: begin
            if (bus.mreq_n) begin
               state_d = ST_IDLE;
            end else begin
               buswait_n_c = 1'b0;
               if (wcnt_zero) begin
                  state_d  = ST_EXT;
                  tmo_load = 1'b1;
               end else begin
                  wcnt_dec = 1'b1;
               end
            end
         end

         ST_EXT: begin
            if (bus.mreq_n) begin
               state_d = ST_IDLE;
            end else if (bus.periph_wait_n) begin
               state_d = ST_DONE;
            end else if (tmo_zero) begin
               // Stuck peripheral: release the CPU this cycle, flag it.
               state_d = ST_DONE;
               tmo_set = 1'b1;
            end else begin
               buswait_n_c = 1'b0;
               tmo_dec     = 1'b1;
            end
         end

         ST_DONE: begin
            if (bus.mreq_n) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.buswait_n = buswait_n_c;
   assign bus.timeout   = timeout_q;

endmodule
